// File: rtl/nor_result_checker.sv
// nor_result_checker
//   Clocked scoreboard for a bitwise-NOR datapath. Each accepted operand pair
//   (a, b) produces the expected value ~(a | b). That value is delayed by the
//   DUT latency LAT and then compared with the DUT result c_i. The block counts
//   vectors and mismatches, captures the first failure, and reports pass/fail
//   once NVEC vectors have been accepted and compared.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i               one-cycle pulse; starts a run from IDLE or DONE
//   vld_i, a_i, b_i       operand vector, accepted only in RUN
//   c_i                   DUT result, aligned LAT cycles after its operands
//   busy_o                run in progress (RUN or DRAIN)
//   done_o, pass_o, fail_o run complete, with its verdict
//   vec_cnt_o, err_cnt_o  vectors accepted / mismatches (saturating) this run
//   fail_idx_o, fail_exp_o, fail_got_o  index, expected and actual value of
//                                       the first mismatch
module nor_result_checker #(
    parameter int WIDTH = 23,
    parameter int LAT   = 1,
    parameter int NVEC  = 10000,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] vec_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] fail_idx_o,
    output logic [WIDTH-1:0] fail_exp_o,
    output logic [WIDTH-1:0] fail_got_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] exp;
        logic [CNT_W-1:0] idx;
    } ent_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NVEC - 1);

    state_t state, state_nxt;
    logic   clr, accept, last_acc, mismatch, pipe_rem;
    ent_t   ent_in, ent_cmp;

    // A new run can only be launched from an idle or finished checker.
    assign clr      = start_i && (state == IDLE || state == DONE);
    assign accept   = vld_i && (state == RUN);
    assign last_acc = accept && (vec_cnt_o == LAST);

    always_comb begin
        ent_in     = '0;
        ent_in.vld = accept;
        ent_in.exp = ~(a_i | b_i);
        ent_in.idx = vec_cnt_o;
    end

    // Expected-value delay line. Stage LAT is the entry compared this cycle;
    // pipe_rem flags entries that are still in flight after this cycle.
    generate
        if (LAT == 0) begin : g_nopipe
            assign ent_cmp  = ent_in;
            assign pipe_rem = 1'b0;
        end else begin : g_pipe
            ent_t pipe [1:LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 1; i <= LAT; i++) pipe[i] <= '0;
                end else if (clr) begin
                    for (int i = 1; i <= LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[1] <= ent_in;
                    for (int i = 2; i <= LAT; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign ent_cmp = pipe[LAT];

            always_comb begin
                pipe_rem = 1'b0;
                for (int i = 1; i < LAT; i++) pipe_rem = pipe_rem | pipe[i].vld;
            end
        end
    endgenerate

    assign mismatch = ent_cmp.vld && (c_i != ent_cmp.exp);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state. DRAIN exits once nothing is left behind the entry being
    // compared now, so the final compare lands in the last DRAIN cycle and
    // its result is already counted when done_o rises.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)   state_nxt = RUN;
            RUN:     if (last_acc)  state_nxt = DRAIN;
            DRAIN:   if (!pipe_rem) state_nxt = DONE;
            DONE:    if (start_i)   state_nxt = RUN;
            default:                state_nxt = IDLE;
        endcase
    end

    // Counters and first-failure capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt_o  <= '0;
            err_cnt_o  <= '0;
            fail_idx_o <= '0;
            fail_exp_o <= '0;
            fail_got_o <= '0;
        end else if (clr) begin
            vec_cnt_o  <= '0;
            err_cnt_o  <= '0;
            fail_idx_o <= '0;
            fail_exp_o <= '0;
            fail_got_o <= '0;
        end else begin
            if (accept) vec_cnt_o <= vec_cnt_o + 1'b1;
            if (mismatch) begin
                if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
                if (err_cnt_o == '0) begin
                    fail_idx_o <= ent_cmp.idx;
                    fail_exp_o <= ent_cmp.exp;
                    fail_got_o <= c_i;
                end
            end
        end
    end

    assign busy_o = (state == RUN) || (state == DRAIN);
    assign done_o = (state == DONE);
    assign pass_o = done_o && (err_cnt_o == '0);
    assign fail_o = done_o && (err_cnt_o != '0);

endmodule
